ika2151_noise_ctrl: RTL

//  Sequencer/configurator for the IKA2151 noise generator. Owns the 32-slot phi1

---
 rtl/ika2151_pkg.sv | 23 ++
 rtl/primitive_counter.sv | 28 ++
 rtl/ika2151_noise_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/ika2151_pkg.sv
// Shared IKA2151 constants: register map, slot numbers and noise register field layout.
package ika2151_pkg;

   localparam logic [7:0] REG_NOISE_ADDR = 8'h0F;
   localparam logic [4:0] SLOT_NOISE     = 5'd31;
   localparam logic [4:0] SLOT_SIGN      = 5'd12;

   localparam int unsigned NOISE_NE_BIT   = 7;
   localparam int unsigned NOISE_NFRQ_MSB = 4;

   typedef struct packed {
      logic       ne;
      logic [4:0] nfrq;
   } noise_reg_t;

   function automatic noise_reg_t unpack_noise(input logic [7:0] data);
      noise_reg_t r;
      r.ne   = data[NOISE_NE_BIT];
      r.nfrq = data[NOISE_NFRQ_MSB:0];
      return r;
   endfunction

endpackage

// File: rtl/primitive_counter.sv
// Generic up-counter with clock enable, synchronous clear and parallel load.
module primitive_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_EMUCLK,
   input  logic             i_RST_n,
   input  logic             i_CEN_n,
   input  logic             i_RST,
   input  logic             i_LD,
   input  logic [WIDTH-1:0] i_D,
   output logic [WIDTH-1:0] o_Q
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         cnt_q <= '0;
      end else if (!i_CEN_n) begin
         if (i_RST)     cnt_q <= '0;
         else if (i_LD) cnt_q <= i_D;
         else           cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_Q = cnt_q;

endmodule

// File: rtl/ika2151_noise_ctrl.sv
// Noise slot sequencer and NE/NFRQ register with frame-boundary commit.
// Define IKA2151_NOISE_IMMEDIATE_EN to commit writes on the edge they are sampled.
module ika2151_noise_ctrl
   import ika2151_pkg::*;
#(
   parameter logic [7:0] NOISE_ADDR  = REG_NOISE_ADDR,
   parameter logic [4:0] COMMIT_SLOT = SLOT_NOISE
) (
   input  logic       i_EMUCLK,
   input  logic       i_MRST_n,
   input  logic       i_phi1_PCEN_n,
   input  logic       i_phi1_NCEN_n,
   input  logic       i_CYCLE_SYNC,
   input  logic       i_REG_WR,
   input  logic [7:0] i_REG_ADDR,
   input  logic [7:0] i_REG_DATA,
   output logic [4:0] o_CYCLE_CNT,
   output logic       o_CYCLE_12,
   output logic       o_CYCLE_15_31,
   output logic       o_NOISE_SEL,
   output logic [4:0] o_NFRQ,
   output logic       o_NE,
   output logic       o_WR_PENDING
);

   logic       unused_pcen;
   logic [1:0] unused_data;
   assign unused_pcen = i_phi1_PCEN_n;
   assign unused_data = i_REG_DATA[6:5];

   logic [4:0] cnt, cnt_nxt;

   primitive_counter #(
      .WIDTH (5)
   ) u_slot_cnt (
      .i_EMUCLK (i_EMUCLK),
      .i_RST_n  (i_MRST_n),
      .i_CEN_n  (i_phi1_NCEN_n),
      .i_RST    (~i_MRST_n | i_CYCLE_SYNC),
      .i_LD     (1'b0),
      .i_D      (5'd0),
      .o_Q      (cnt)
   );

   logic       cyc12_q, cyc1531_q, sel_q;
   noise_reg_t cur_q, cur_d;
   noise_reg_t wr_val;
   logic       wr_hit;
   logic       pend_q, pend_d;

`ifdef IKA2151_NOISE_IMMEDIATE_EN
   logic [4:0] unused_commit_slot;
   assign unused_commit_slot = COMMIT_SLOT;
`else
   noise_reg_t shadow_q, shadow_d;
`endif

   always_comb begin
      cnt_nxt = i_CYCLE_SYNC ? 5'd0 : cnt + 5'd1;
      wr_hit  = i_REG_WR && (i_REG_ADDR == NOISE_ADDR);
      wr_val  = unpack_noise(i_REG_DATA);
      cur_d   = cur_q;
      pend_d  = 1'b0;
`ifdef IKA2151_NOISE_IMMEDIATE_EN
      if (wr_hit) cur_d = wr_val;
`else
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (wr_hit) shadow_d = wr_val;
      // A write landing on the commit edge bypasses the shadow and never shows as pending.
      if (cnt == COMMIT_SLOT && (pend_q || wr_hit)) begin
         cur_d  = wr_hit ? wr_val : shadow_q;
         pend_d = 1'b0;
      end else if (wr_hit) begin
         pend_d = 1'b1;
      end
`endif
   end

   // Strobes decode the next count so they line up with o_CYCLE_CNT.
   always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         cyc12_q   <= 1'b0;
         cyc1531_q <= 1'b0;
         sel_q     <= 1'b0;
         cur_q     <= '0;
         pend_q    <= 1'b0;
`ifndef IKA2151_NOISE_IMMEDIATE_EN
         shadow_q  <= '0;
`endif
      end else if (!i_phi1_NCEN_n) begin
         cyc12_q   <= (cnt_nxt == SLOT_SIGN);
         cyc1531_q <= (cnt_nxt[3:0] == 4'hF);
         sel_q     <= (cnt_nxt == SLOT_NOISE) && cur_d.ne;
         cur_q     <= cur_d;
         pend_q    <= pend_d;
`ifndef IKA2151_NOISE_IMMEDIATE_EN
         shadow_q  <= shadow_d;
`endif
      end
   end

   assign o_CYCLE_CNT   = cnt;
   assign o_CYCLE_12    = cyc12_q;
   assign o_CYCLE_15_31 = cyc1531_q;
   assign o_NOISE_SEL   = sel_q;
   assign o_NFRQ        = cur_q.nfrq;
   assign o_NE          = cur_q.ne;
   assign o_WR_PENDING  = pend_q;

endmodule
